// File: rtl/fifo_sync_flex_if.sv
// Handshake bundle for fifo_sync_flex: producer/consumer controls on one side, data and status on the other.
// The master modport is the user side and the slave modport is the FIFO side.
interface fifo_sync_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   din;
  logic                    rd_en;
  logic                    clr_err;
  logic [DATA_WIDTH-1:0]   dout;
  logic                    valid;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with selectable registered / first-word-fall-through read, programmable
// almost thresholds, sticky overflow/underflow flags, and any DEPTH >= 2.
module fifo_sync_flex #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 8,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_flex_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);
  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);

  data_t mem [DEPTH];

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  count_q, count_d;
  data_t dout_q, dout_d;
  logic  valid_q, valid_d;
  logic  overflow_q, overflow_d;
  logic  underflow_q, underflow_d;

  logic empty, full, rd_acc, wr_acc;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_C);
  assign rd_acc = bus.rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a write.
  assign wr_acc = bus.wr_en & (~full | rd_acc);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // Explicit wrap compare keeps non-power-of-two depths correct.
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ptr_t'(1);
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ptr_t'(1);
      dout_d   = mem[rd_ptr_q];
      valid_d  = 1'b1;
    end

    if (wr_acc && !rd_acc)      count_d = count_q + cnt_t'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - cnt_t'(1);

    // Clear first so a fresh error in the same cycle takes priority.
    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.wr_en && !wr_acc) overflow_d  = 1'b1;
    if (bus.rd_en && !rd_acc) underflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage has no reset; stale words are unreachable because count and pointers are reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.din;
  end

  assign bus.dout         = FWFT ? (empty ? '0 : mem[rd_ptr_q]) : dout_q;
  assign bus.valid        = FWFT ? ~empty : valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= cnt_t'(AFULL_THRESH));
  assign bus.almost_empty = (count_q <= cnt_t'(AEMPTY_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_flex.sv
// Directed bench for fifo_sync_flex: three instances (8-deep registered, 6-deep registered, 4-deep FWFT)
// stepped one clock at a time with outputs sampled 1 time unit after each rising edge.
module tb_fifo_sync_flex;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fifo_sync_flex_if #(.DATA_WIDTH(8), .DEPTH(8)) a_if ();
  fifo_sync_flex_if #(.DATA_WIDTH(8), .DEPTH(6)) b_if ();
  fifo_sync_flex_if #(.DATA_WIDTH(8), .DEPTH(4)) c_if ();

  fifo_sync_flex #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1'b0), .AFULL_THRESH(6), .AEMPTY_THRESH(1))
    u_a (.clk(clk), .rst(rst), .bus(a_if));
  fifo_sync_flex #(.DATA_WIDTH(8), .DEPTH(6), .FWFT(1'b0), .AFULL_THRESH(4), .AEMPTY_THRESH(1))
    u_b (.clk(clk), .rst(rst), .bus(b_if));
  fifo_sync_flex #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1'b1), .AFULL_THRESH(2), .AEMPTY_THRESH(1))
    u_c (.clk(clk), .rst(rst), .bus(c_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_count"}, 32'(a_if.count), 32'd0);
    check({tag, "_dout"},  32'(a_if.dout),  32'd0);
    check({tag, "_valid"}, 32'(a_if.valid), 32'd0);
    check({tag, "_full"},  32'(a_if.full),  32'd0);
    check({tag, "_empty"}, 32'(a_if.empty), 32'd1);
    check({tag, "_af"},    32'(a_if.almost_full),  32'd0);
    check({tag, "_ae"},    32'(a_if.almost_empty), 32'd1);
    check({tag, "_ovf"},   32'(a_if.overflow),  32'd0);
    check({tag, "_udf"},   32'(a_if.underflow), 32'd0);
  endtask

  logic [7:0] model_q[$];
  logic [7:0] exp_d;
  logic       w, r, racc, wacc, m_ovf, m_udf;

  initial begin
    rst = 1'b1;
    {a_if.wr_en, a_if.rd_en, a_if.clr_err} = '0; a_if.din = '0;
    {b_if.wr_en, b_if.rd_en, b_if.clr_err} = '0; b_if.din = '0;
    {c_if.wr_en, c_if.rd_en, c_if.clr_err} = '0; c_if.din = '0;
    tick();
    tick();
    check_a_reset("reset");
    rst = 1'b0;

    // Fill the 8-deep FIFO and watch the flags climb.
    for (int i = 0; i < 8; i++) begin
      a_if.wr_en = 1'b1; a_if.din = 8'(8'h10 + i);
      tick();
      check("fill_count", 32'(a_if.count), 32'(i + 1));
      check("fill_af",    32'(a_if.almost_full),  32'((i + 1) >= 6));
      check("fill_full",  32'(a_if.full),         32'((i + 1) == 8));
      check("fill_ae",    32'(a_if.almost_empty), 32'((i + 1) <= 1));
    end
    a_if.din = 8'hAA;
    tick();
    check("ovf_set",   32'(a_if.overflow), 32'd1);
    check("ovf_count", 32'(a_if.count),    32'd8);
    a_if.wr_en = 1'b0;

    // Drain: data appears one cycle after each accepted read.
    for (int i = 0; i < 8; i++) begin
      a_if.rd_en = 1'b1;
      tick();
      check("drain_dout",  32'(a_if.dout),  32'(8'h10 + i));
      check("drain_valid", 32'(a_if.valid), 32'd1);
      check("drain_count", 32'(a_if.count), 32'(7 - i));
    end
    check("drain_empty", 32'(a_if.empty), 32'd1);
    tick();
    check("udf_set",   32'(a_if.underflow), 32'd1);
    check("udf_valid", 32'(a_if.valid),     32'd0);
    check("udf_dout",  32'(a_if.dout),      32'h17);
    a_if.rd_en = 1'b0; a_if.clr_err = 1'b1;
    tick();
    check("clr_ovf", 32'(a_if.overflow),  32'd0);
    check("clr_udf", 32'(a_if.underflow), 32'd0);
    a_if.clr_err = 1'b0;

    // Simultaneous read+write at full.
    for (int i = 0; i < 8; i++) begin
      a_if.wr_en = 1'b1; a_if.din = 8'(8'h20 + i);
      tick();
    end
    a_if.rd_en = 1'b1; a_if.din = 8'h28;
    tick();
    check("rw_full_count", 32'(a_if.count),    32'd8);
    check("rw_full_full",  32'(a_if.full),     32'd1);
    check("rw_full_dout",  32'(a_if.dout),     32'h20);
    check("rw_full_ovf",   32'(a_if.overflow), 32'd0);
    a_if.wr_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("rw_full_order", 32'(a_if.dout), 32'(8'h20 + i));
    end
    a_if.rd_en = 1'b0;
    tick();
    check("rw_pre_empty", 32'(a_if.empty), 32'd1);

    // Simultaneous read+write at empty: write wins, read rejected.
    a_if.wr_en = 1'b1; a_if.rd_en = 1'b1; a_if.din = 8'h33;
    tick();
    check("rw_empty_count", 32'(a_if.count),     32'd1);
    check("rw_empty_udf",   32'(a_if.underflow), 32'd1);
    check("rw_empty_valid", 32'(a_if.valid),     32'd0);
    check("rw_empty_dout",  32'(a_if.dout),      32'h28);
    a_if.wr_en = 1'b0;
    tick();
    check("rw_empty_read", 32'(a_if.dout),  32'h33);
    check("rw_empty_cnt0", 32'(a_if.count), 32'd0);
    a_if.rd_en = 1'b0; a_if.clr_err = 1'b1;
    tick();
    a_if.clr_err = 1'b0;

    // 6-deep FIFO: random traffic against a queue model across several wraps.
    void'($urandom(32'd2024));
    m_ovf = 1'b0; m_udf = 1'b0;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      b_if.wr_en = w; b_if.rd_en = r; b_if.din = 8'($urandom_range(0, 255));
      racc = r && (model_q.size() != 0);
      wacc = w && ((model_q.size() != 6) || racc);
      if (racc) exp_d = model_q.pop_front();
      if (wacc) model_q.push_back(b_if.din);
      if (w && !wacc) m_ovf = 1'b1;
      if (r && !racc) m_udf = 1'b1;
      tick();
      check("rand_count", 32'(b_if.count),     32'(model_q.size()));
      check("rand_valid", 32'(b_if.valid),     32'(racc));
      if (racc) check("rand_dout", 32'(b_if.dout), 32'(exp_d));
      check("rand_ovf",   32'(b_if.overflow),  32'(m_ovf));
      check("rand_udf",   32'(b_if.underflow), 32'(m_udf));
    end
    b_if.wr_en = 1'b0; b_if.rd_en = 1'b0;

    // FWFT instance: head word visible without a read.
    c_if.wr_en = 1'b1; c_if.din = 8'h55;
    tick();
    c_if.wr_en = 1'b0;
    check("fwft_valid", 32'(c_if.valid), 32'd1);
    check("fwft_dout",  32'(c_if.dout),  32'h55);
    c_if.wr_en = 1'b1; c_if.din = 8'h66;
    tick();
    c_if.wr_en = 1'b0;
    check("fwft_head", 32'(c_if.dout),  32'h55);
    check("fwft_cnt2", 32'(c_if.count), 32'd2);
    c_if.rd_en = 1'b1;
    tick();
    check("fwft_pop_dout",  32'(c_if.dout),  32'h66);
    check("fwft_pop_count", 32'(c_if.count), 32'd1);
    check("fwft_pop_valid", 32'(c_if.valid), 32'd1);
    tick();
    c_if.rd_en = 1'b0;
    check("fwft_empty_valid", 32'(c_if.valid), 32'd0);
    check("fwft_empty",       32'(c_if.empty), 32'd1);

    // Error-flag priority: set beats clear.
    for (int i = 0; i < 8; i++) begin
      a_if.wr_en = 1'b1; a_if.din = 8'(8'h40 + i);
      tick();
    end
    tick();
    check("err_ovf", 32'(a_if.overflow), 32'd1);
    a_if.clr_err = 1'b1;
    tick();
    check("err_set_wins", 32'(a_if.overflow), 32'd1);
    a_if.wr_en = 1'b0;
    tick();
    check("err_cleared", 32'(a_if.overflow), 32'd0);
    a_if.clr_err = 1'b0;

    // Asynchronous reset in the middle of a read burst at count 5.
    a_if.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("burst_count", 32'(a_if.count), 32'd5);
    check("burst_valid", 32'(a_if.valid), 32'd1);
    #2 rst = 1'b1;
    #1 check_a_reset("async_rst");
    a_if.rd_en = 1'b0;
    tick();
    rst = 1'b0;
    a_if.wr_en = 1'b1; a_if.din = 8'h77;
    tick();
    a_if.wr_en = 1'b0; a_if.rd_en = 1'b1;
    check("post_rst_count", 32'(a_if.count), 32'd1);
    tick();
    a_if.rd_en = 1'b0;
    check("post_rst_dout",  32'(a_if.dout),  32'h77);
    check("post_rst_valid", 32'(a_if.valid), 32'd1);
    check("post_rst_empty", 32'(a_if.empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_sync_flex.md
Name: fifo_sync_flex

Overview:
Parametrised single-clock FIFO, successor to the basic synchronous FIFO. Adds a selectable read mode (registered-output or first-word-fall-through), programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It supports non-power-of-two depth and accepts a write on a full FIFO when a read happens in the same cycle. It serves as the general-purpose buffer between streaming producer/consumer blocks.

Parameters:
DATA_WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries (>=2, not required to be a power of two)
FWFT, 0, read mode: 0 = registered output, 1 = first-word-fall-through
AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value
AEMPTY_THRESH, 1, almost_empty asserts when count <= this value

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write request
din  in  DATA_WIDTH  write data
rd_en  in  1  read request (pop in FWFT mode)
clr_err  in  1  synchronous clear of overflow/underflow
dout  out  DATA_WIDTH  read data
valid  out  1  dout holds valid data (meaning depends on mode)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_THRESH
almost_empty  out  1  count <= AEMPTY_THRESH
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (async, immediate): wr_ptr=rd_ptr=0, count=0, dout=0, valid=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0. Memory contents are not cleared and are never observable after reset.
- Read acceptance: rd_acc = rd_en & !empty.
- Write acceptance: wr_acc = wr_en & (!full | rd_acc). At full, a simultaneous read+write is accepted and count is unchanged. At empty, a simultaneous read+write accepts the write, rejects the read, and gives count=1.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- Pointers: increment on acceptance; wrap from DEPTH-1 to 0 (explicit compare, not bit truncation).
- Flags (full, empty, almost_full, almost_empty) are decoded from the registered count. They reflect the post-edge state, valid in the cycle after the accepting edge.
- FWFT=0 mode:
  - On rd_acc, dout <= mem[rd_ptr] at that edge and valid=1 for exactly one cycle. Read latency is 1 cycle.
  - Otherwise dout holds its last value and valid=0.
- FWFT=1 mode:
  - dout = mem[rd_ptr] whenever !empty, and valid = !empty.
  - A word written into an empty FIFO appears on dout with valid=1 in the cycle after the write edge.
  - rd_en pops the head; the next head (if any) appears the cycle after the pop edge.
  - When empty, dout is don't-care and valid=0.
- overflow: set on wr_en & !wr_acc. underflow: set on rd_en & !rd_acc.
  - Both stay set until clr_err. If clr_err and a new error occur in the same cycle, set wins.
- Rejected operations change no state except the error flags.
- Reset during a burst aborts all operations. Post-reset behaviour is identical to power-up.

Test Plan:
1. DEPTH=8, FWFT=0, AFULL_THRESH=6: write 0x10..0x17 on consecutive cycles -> count steps 1..8, almost_full rises after 6th write, full after 8th. A 9th write of 0xAA is rejected: overflow=1, count=8.
2. Same instance, rd_en for 8 cycles -> dout=0x10..0x17 each one cycle after its rd_en, with valid pulsing. empty=1 after the last read. An extra rd_en gives underflow=1, valid=0, and dout holds 0x17.
3. Simultaneous rd_en+wr_en:
   - At full (count=8): count stays 8, full stays 1, output order is preserved.
   - At empty: the write of 0x33 is accepted, underflow=1, count=1.
4. DEPTH=6 instance: 40 random interleaved reads/writes with a scoreboard -> data order matches across multiple pointer wraps, count always matches the model, no spurious error flags.
5. FWFT=1, DEPTH=4: write 0x55 to empty -> next cycle valid=1, dout=0x55 with no rd_en. Write 0x66, then pulse rd_en once -> dout=0x66 next cycle, count=1.
6. Error flag and reset handling:
   - clr_err in the same cycle as a rejected write -> overflow stays 1. clr_err alone -> overflow=0.
   - Assert rst asynchronously mid-burst at count=5 -> all outputs reach reset values before the next clk edge.
